intt_gs_bf_pipe: RTL and testbench

//  Pipelined Gentleman-Sande inverse-NTT butterfly over Z_q (q = 3329). Per accepted

---
 rtl/intt_gs_bf_pipe.sv | 122 ++++++++++++
 tb/tb_intt_gs_bf_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/intt_gs_bf_pipe.sv
// Gentleman-Sande inverse-NTT butterfly over Z_q, four register stages.
// Streams one (a, b, w) set per cycle into sum = a+b and prod = (a-b)*w mod q.
module intt_gs_bf_pipe #(
  parameter int Q         = 3329,
  parameter int W         = 12,
  parameter int BARRETT_M = 5039,
  parameter int BARRETT_K = 24,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [W-1:0]     out_prod,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = 2 * W;
  localparam int MW = PW + $clog2(BARRETT_M + 1);

  localparam logic [W:0]    QX = (W + 1)'(Q);
  localparam logic [W-1:0]  QW = W'(Q);
  localparam logic [PW-1:0] QP = PW'(Q);
  localparam logic [MW-1:0] MM = MW'(BARRETT_M);

  logic adv;

  logic             v1_q, v2_q, v3_q, v4_q;
  logic [W-1:0]     sum1_q, sum2_q, sum3_q, sum4_q;
  logic [W-1:0]     diff1_q, w1_q;
  logic [PW-1:0]    p2_q;
  logic [W:0]       r3_q;
  logic [W-1:0]     prod4_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;

  logic [W-1:0]     sum1_d, diff1_d;
  logic [PW-1:0]    p2_d;
  logic [W:0]       r3_d;
  logic [W-1:0]     prod4_d;

  logic [W:0]       sum_raw, diff_raw;
  logic [MW-1:0]    pm, t_full;
  logic [PW-1:0]    tq;

  assign adv       = out_ready | ~v4_q;
  assign in_ready  = adv;
  assign out_valid = v4_q;
  assign out_sum   = sum4_q;
  assign out_prod  = prod4_q;
  assign out_tag   = tag4_q;

  always_comb begin
    sum_raw  = {1'b0, in_a} + {1'b0, in_b};
    diff_raw = {1'b0, in_a} - {1'b0, in_b};
    sum1_d   = (sum_raw >= QX) ? W'(sum_raw - QX) : W'(sum_raw);
    // borrow bit set means a < b, so fold back into [0,Q)
    diff1_d  = diff_raw[W] ? (diff_raw[W-1:0] + QW) : diff_raw[W-1:0];
  end

  always_comb begin
    p2_d = PW'(diff1_q) * PW'(w1_q);
  end

  always_comb begin
    pm     = MW'(p2_q) * MM;
    t_full = pm >> BARRETT_K;
    tq     = PW'(t_full) * QP;
    r3_d   = (W + 1)'(p2_q - tq);
  end

  always_comb begin
    prod4_d = (r3_q >= QX) ? W'(r3_q - QX) : W'(r3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      sum1_q  <= '0;
      diff1_q <= '0;
      w1_q    <= '0;
      tag1_q  <= '0;
      sum2_q  <= '0;
      p2_q    <= '0;
      tag2_q  <= '0;
      sum3_q  <= '0;
      r3_q    <= '0;
      tag3_q  <= '0;
      sum4_q  <= '0;
      prod4_q <= '0;
      tag4_q  <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sum1_q  <= sum1_d;
      diff1_q <= diff1_d;
      w1_q    <= in_w;
      tag1_q  <= in_tag;
      v2_q    <= v1_q;
      sum2_q  <= sum1_q;
      p2_q    <= p2_d;
      tag2_q  <= tag1_q;
      v3_q    <= v2_q;
      sum3_q  <= sum2_q;
      r3_q    <= r3_d;
      tag3_q  <= tag2_q;
      v4_q    <= v3_q;
      sum4_q  <= sum3_q;
      prod4_q <= prod4_d;
      tag4_q  <= tag3_q;
    end
  end

endmodule

// File: tb/tb_intt_gs_bf_pipe.sv
// Bench for intt_gs_bf_pipe: directed corners plus random
// streams scored against a modular-arithmetic reference queue.
module tb_intt_gs_bf_pipe;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0, in_b = '0, in_w = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sum, out_prod;
  logic [7:0]  out_tag;

  intt_gs_bf_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_w     (in_w),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_prod (out_prod),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int prod;
    int tag;
    bit dc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pushed = 0;
  int popped = 0;
  bit hold = 1'b0;
  logic [11:0] h_sum, h_prod, l_sum, l_prod;
  logic [7:0]  h_tag, l_tag;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, obs, expv, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b,
                                 input int w, input int tg);
    exp_t e;
    e.sum  = (a + b) % Q;
    e.prod = (((a - b + Q) % Q) * w) % Q;
    e.tag  = tg;
    e.dc   = (a >= Q) || (b >= Q) || (w >= Q);
    return e;
  endfunction

  task automatic step(input bit iv, input int a, input int b,
                      input int w, input int tg, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a[11:0];
    in_b      = b[11:0];
    in_w      = w[11:0];
    in_tag    = tg[7:0];
    out_ready = ordy;
    #1;
    cyc++;
    if (hold) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {20'd0, out_sum}, {20'd0, h_sum});
      chk("hold_prod", {20'd0, out_prod}, {20'd0, h_prod});
      chk("hold_tag", {24'd0, out_tag}, {24'd0, h_tag});
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tag", {24'd0, out_tag}, e.tag);
        if (e.dc) begin
          chk("no_x", {31'd0, $isunknown({out_sum, out_prod})}, 32'd0);
        end else begin
          chk("sum", {20'd0, out_sum}, e.sum);
          chk("prod", {20'd0, out_prod}, e.prod);
        end
      end
      popped++;
      l_sum  = out_sum;
      l_prod = out_prod;
      l_tag  = out_tag;
    end
    hold   = out_valid && !out_ready;
    h_sum  = out_sum;
    h_prod = out_prod;
    h_tag  = out_tag;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, w, tg));
      pushed++;
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 0, 0, 0, 0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);
  endtask

  task automatic one(input int a, input int b, input int w,
                     input int tg, input int es, input int ep);
    int lat;
    lat = 0;
    step(1'b1, a, b, w, tg, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      idle(1'b1);
      if (lat == 0 && out_valid) lat = i;
    end
    chk("latency", lat, 32'd4);
    chk("dir_sum", {20'd0, l_sum}, es);
    chk("dir_prod", {20'd0, l_prod}, ep);
    chk("dir_tag", {24'd0, l_tag}, tg);
  endtask

  function automatic int rv();
    return int'($urandom_range(0, Q - 1));
  endfunction

  initial begin
    int first, last, p0, seen;
    exp_t e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {20'd0, out_sum}, 32'd0);
    chk("rst_prod", {20'd0, out_prod}, 32'd0);
    chk("rst_tag", {24'd0, out_tag}, 32'd0);

    one(3000, 1000, 17, 8'h5a, 671, 710);
    one(0, 1, 1, 1, 1, 3328);
    one(3328, 0, 3328, 2, 3328, 1);
    one(3328, 3328, 3328, 3, 3327, 0);

    // back-to-back burst, tags 0..255
    p0 = popped;
    first = -1;
    last = -1;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, rv(), rv(), rv(), i, 1'b1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("burst_count", popped - p0, 32'd256);
    chk("burst_gapless", last - first + 1, 32'd256);
    drain();

    // mid-burst stall
    for (int i = 0; i < 10; i++) step(1'b1, rv(), rv(), rv(), i, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rv(), rv(), rv(), 100 + i, 1'b0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    for (int i = 0; i < 6; i++) step(1'b1, rv(), rv(), rv(), 200 + i, 1'b1);
    drain();

    // reset with three sets in flight
    for (int i = 0; i < 3; i++) step(1'b1, rv(), rv(), rv(), 50 + i, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    hold = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    e = model(1234, 2345, 999, 77);
    one(1234, 2345, 999, 77, e.sum, e.prod);
    drain();

    // illegal operands: flow and tag intact, no X
    step(1'b1, 4095, 4095, 4095, 11, 1'b1);
    step(1'b1, 3329, 0, 4000, 12, 1'b1);
    step(1'b1, 0, 4095, 3500, 13, 1'b1);
    step(1'b1, 10, 20, 30, 14, 1'b1);
    drain();

    // random valid/ready traffic, 10k sets
    p0 = pushed;
    seen = 0;
    while (pushed - p0 < 10000 && seen < 60000) begin
      step($urandom_range(0, 3) != 0, rv(), rv(), rv(),
           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
      seen++;
    end
    chk("rand_accepted", pushed - p0, 32'd10000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
